sys_cntr: RTL and testbench

//  Parametrised bounded counter: registered successor of the WRAP/SAT macros.

---
 rtl/sys_cntr_pkg.sv | 28 ++
 rtl/sys_cntr_next.sv | 71 +++++++
 rtl/sys_cntr.sv | 116 +++++++++++
 tb/tb_sys_cntr.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cntr_pkg.sv
// Shared types and helpers for the bounded counter family (sys_cntr and friends).
package sys_cntr_pkg;

    // Counting discipline when a step crosses a bound.
    typedef enum logic {
        CNTR_WRAP = 1'b0,
        CNTR_SAT  = 1'b1
    } cntr_mode_e;

    // Safe ceil(log2(n)) that never collapses a derived width below 1 bit.
    function automatic int unsigned sclog2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a value into [lo..hi]; wide enough for any counter up to 32 bits.
    function automatic logic [32:0] clamp(input logic [32:0] val,
                                          input logic [32:0] lo,
                                          input logic [32:0] hi);
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/sys_cntr_next.sv
// Combinational successor of a bounded counter: given the current count,
// direction and step, produce the next count and the wrap/saturate events.
// Kept standalone so multi-pointer FIFOs can reuse it without the registers.
module sys_cntr_next
    import sys_cntr_pkg::*;
#(
    parameter int unsigned  W      = 8,
    parameter int unsigned  STEP_W = 1,
    parameter logic [W-1:0] MIN    = '0,
    parameter logic [W-1:0] MAX    = '1,
    parameter cntr_mode_e   MODE   = CNTR_WRAP
) (
    input  logic [W-1:0]      cnt,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      nxt,
    output logic              wrap,
    output logic              sat
);

    // One bit wider than the widest operand so sums and RNG itself never overflow.
    localparam int unsigned    AW    = ((W > STEP_W) ? W : STEP_W) + 1;
    localparam logic [AW-1:0]  MIN_A = AW'(MIN);
    localparam logic [AW-1:0]  MAX_A = AW'(MAX);
    localparam logic [AW-1:0]  RNG_A = MAX_A - MIN_A + AW'(1);

    logic [AW-1:0] cnt_a;
    logic [AW-1:0] step_a;
    logic [AW-1:0] s;
    logic [AW-1:0] sum;
    logic [AW-1:0] lo_lim;

    assign cnt_a  = AW'(cnt);
    assign step_a = AW'(step);
    assign s      = (step_a > RNG_A) ? RNG_A : step_a;
    assign sum    = cnt_a + s;
    assign lo_lim = MIN_A + s;

    // Apply the step, folding or clamping at the bounds; exact landings are not events.
    always_comb begin
        nxt  = cnt;
        wrap = 1'b0;
        sat  = 1'b0;
        if (dir) begin
            if (sum > MAX_A) begin
                if (MODE == CNTR_WRAP) begin
                    nxt  = W'(sum - RNG_A);
                    wrap = 1'b1;
                end else begin
                    nxt  = MAX;
                    sat  = 1'b1;
                end
            end else begin
                nxt = W'(sum);
            end
        end else begin
            if (cnt_a < lo_lim) begin
                if (MODE == CNTR_WRAP) begin
                    nxt  = W'(cnt_a + RNG_A - s);
                    wrap = 1'b1;
                end else begin
                    nxt  = MIN;
                    sat  = 1'b1;
                end
            end else begin
                nxt = W'(cnt_a - s);
            end
        end
    end

endmodule

// File: rtl/sys_cntr.sv
// Parametrised bounded counter over [MIN..MAX] with runtime step/direction,
// wrap or saturate mode, synchronous clear/load and one-cycle event pulses.
// Optional build macro SYS_CNTR_STICKY_EN adds o_evt_sticky, a flag that
// remembers any wrap/sat event until i_clr or reset.
module sys_cntr
    import sys_cntr_pkg::*;
#(
    parameter int unsigned  W       = 8,
    parameter logic [W-1:0] MIN     = '0,
    parameter logic [W-1:0] MAX     = '1,
    parameter logic [W-1:0] RST_VAL = MIN,
    parameter int unsigned  STEP_W  = 1,
    parameter cntr_mode_e   MODE    = CNTR_WRAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [W-1:0]      i_load_val,
    input  logic              i_en,
    input  logic              i_dir,
    input  logic [STEP_W-1:0] i_step,
    output logic [W-1:0]      o_cnt,
    output logic              o_at_max,
    output logic              o_at_min,
    output logic              o_wrap,
    output logic              o_sat
`ifdef SYS_CNTR_STICKY_EN
    ,
    output logic              o_evt_sticky
`endif
);

    logic [W-1:0] cnt_q;
    logic         wrap_q;
    logic         sat_q;

    logic [W-1:0] step_nxt;
    logic         step_wrap;
    logic         step_sat;
    logic [W-1:0] load_val_c;

    logic [W-1:0] cnt_d;
    logic         wrap_d;
    logic         sat_d;

    sys_cntr_next #(
        .W      (W),
        .STEP_W (STEP_W),
        .MIN    (MIN),
        .MAX    (MAX),
        .MODE   (MODE)
    ) u_next (
        .cnt  (cnt_q),
        .dir  (i_dir),
        .step (i_step),
        .nxt  (step_nxt),
        .wrap (step_wrap),
        .sat  (step_sat)
    );

    assign load_val_c = W'(clamp(33'(i_load_val), 33'(MIN), 33'(MAX)));

    // Command priority: clear beats load beats count; only counting raises events.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (i_clr) begin
            cnt_d = RST_VAL;
        end else if (i_load) begin
            cnt_d = load_val_c;
        end else if (i_en) begin
            cnt_d  = step_nxt;
            wrap_d = step_wrap;
            sat_d  = step_sat;
        end
    end

    // Count and event pulses all update on the edge that consumes the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

`ifdef SYS_CNTR_STICKY_EN
    logic sticky_q;

    // Latch any event alongside its pulse; only clear or reset forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (i_clr) begin
            sticky_q <= 1'b0;
        end else if (wrap_d || sat_d) begin
            sticky_q <= 1'b1;
        end
    end

    assign o_evt_sticky = sticky_q;
`endif

    assign o_cnt    = cnt_q;
    assign o_wrap   = wrap_q;
    assign o_sat    = sat_q;
    assign o_at_max = (cnt_q == MAX);
    assign o_at_min = (cnt_q == MIN);

endmodule

// File: tb/tb_sys_cntr.sv
// Testbench for sys_cntr: one WRAP and one SAT instance share the same stimulus
// and are compared against an offset/modulo reference model.
// Build with SYS_CNTR_STICKY_EN defined to also exercise o_evt_sticky.
module tb_sys_cntr;
    import sys_cntr_pkg::*;

    localparam int W      = 4;
    localparam int STEP_W = 4;
    localparam int MIN_I  = 2;
    localparam int MAX_I  = 9;
    localparam int RST_I  = 2;
    localparam int RNG_I  = MAX_I - MIN_I + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              load = 1'b0;
    logic [W-1:0]      load_val = '0;
    logic              en = 1'b0;
    logic              dir = 1'b0;
    logic [STEP_W-1:0] step = '0;

    logic [W-1:0] w_cnt, s_cnt;
    logic         w_at_max, w_at_min, w_wrap, w_sat;
    logic         s_at_max, s_at_min, s_wrap, s_sat;
`ifdef SYS_CNTR_STICKY_EN
    logic         w_sticky, s_sticky;
`endif

    int checks = 0;
    int errors = 0;

    int m_w_cnt, m_s_cnt;
    bit m_w_wrap, m_w_sat, m_s_wrap, m_s_sat;
    bit m_w_sticky, m_s_sticky;

    always #5 clk = ~clk;

    sys_cntr #(
        .W(W), .MIN(4'd2), .MAX(4'd9), .RST_VAL(4'd2), .STEP_W(STEP_W), .MODE(CNTR_WRAP)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_en(en), .i_dir(dir), .i_step(step), .o_cnt(w_cnt), .o_at_max(w_at_max),
        .o_at_min(w_at_min), .o_wrap(w_wrap), .o_sat(w_sat)
`ifdef SYS_CNTR_STICKY_EN
        , .o_evt_sticky(w_sticky)
`endif
    );

    sys_cntr #(
        .W(W), .MIN(4'd2), .MAX(4'd9), .RST_VAL(4'd2), .STEP_W(STEP_W), .MODE(CNTR_SAT)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_en(en), .i_dir(dir), .i_step(step), .o_cnt(s_cnt), .o_at_max(s_at_max),
        .o_at_min(s_at_min), .o_wrap(s_wrap), .o_sat(s_sat)
`ifdef SYS_CNTR_STICKY_EN
        , .o_evt_sticky(s_sticky)
`endif
    );

    // Reference: work on the offset from MIN, fold with modulo or clamp to the range.
    task automatic model_next(input int cur, input bit sat_mode,
                              output int nxt, output bit wr, output bit st);
        int s, off, raw;
        nxt = cur;
        wr  = 1'b0;
        st  = 1'b0;
        if (clr) begin
            nxt = RST_I;
        end else if (load) begin
            nxt = int'(load_val);
            if (nxt < MIN_I) nxt = MIN_I;
            if (nxt > MAX_I) nxt = MAX_I;
        end else if (en) begin
            s = int'(step);
            if (s > RNG_I) s = RNG_I;
            if (s != 0) begin
                off = cur - MIN_I;
                raw = dir ? off + s : off - s;
                if (!sat_mode) begin
                    if (raw < 0 || raw >= RNG_I) wr = 1'b1;
                    nxt = ((raw % RNG_I) + RNG_I) % RNG_I + MIN_I;
                end else if (raw >= RNG_I) begin
                    nxt = MAX_I;
                    st  = 1'b1;
                end else if (raw < 0) begin
                    nxt = MIN_I;
                    st  = 1'b1;
                end else begin
                    nxt = raw + MIN_I;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_w_cnt = RST_I;  m_s_cnt = RST_I;
        m_w_wrap = 0; m_w_sat = 0; m_s_wrap = 0; m_s_sat = 0;
        m_w_sticky = 0; m_s_sticky = 0;
    endtask

    // Advance one clock with the current inputs and move the model along with it.
    task automatic cycle();
        int nw, ns;
        bit a, b, c, d;
        model_next(m_w_cnt, 1'b0, nw, a, b);
        model_next(m_s_cnt, 1'b1, ns, c, d);
        @(posedge clk);
        #1;
        m_w_sticky = clr ? 1'b0 : (m_w_sticky | a | b);
        m_s_sticky = clr ? 1'b0 : (m_s_sticky | c | d);
        m_w_cnt = nw; m_w_wrap = a; m_w_sat = b;
        m_s_cnt = ns; m_s_wrap = c; m_s_sat = d;
    endtask

    task automatic drive(input bit c, input bit l, input int lv,
                         input bit e, input bit d, input int st);
        clr      = c;
        load     = l;
        load_val = W'(lv);
        en       = e;
        dir      = d;
        step     = STEP_W'(st);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++; if (w_cnt !== 4'd2) begin errors++; $display("FAIL reset_cnt got %0d want 2", w_cnt); end
        checks++; if ({w_wrap, w_sat, s_wrap, s_sat} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b want 0000", {w_wrap, w_sat, s_wrap, s_sat}); end
        checks++; if ({w_at_min, w_at_max} !== 2'b10) begin errors++; $display("FAIL reset_flags got %b want 10", {w_at_min, w_at_max}); end
`ifdef SYS_CNTR_STICKY_EN
        checks++; if (w_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", w_sticky); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        drive(0, 1, 8, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 1, 3); cycle();
        checks++; if (w_cnt !== 4'd3) begin errors++; $display("FAIL wrap_up_cnt got %0d want 3", w_cnt); end
        checks++; if (w_wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_pulse got %b want 1", w_wrap); end
        cycle();
        checks++; if (w_cnt !== 4'd6) begin errors++; $display("FAIL wrap_up2_cnt got %0d want 6", w_cnt); end
        checks++; if (w_wrap !== 1'b0) begin errors++; $display("FAIL wrap_up2_pulse got %b want 0", w_wrap); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask

    task automatic test_wrap_down();
        drive(0, 1, 3, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 0, 3); cycle();
        checks++; if (w_cnt !== 4'd8 || w_wrap !== 1'b1) begin errors++; $display("FAIL wrap_down got %0d/%b want 8/1", w_cnt, w_wrap); end
        drive(0, 1, 5, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 0, 8); cycle();
        checks++; if (w_cnt !== 4'd5 || w_wrap !== 1'b1) begin errors++; $display("FAIL wrap_full_rng got %0d/%b want 5/1", w_cnt, w_wrap); end
        drive(0, 0, 0, 1, 1, 15); cycle();
        checks++; if (w_cnt !== 4'd5 || w_wrap !== 1'b1) begin errors++; $display("FAIL wrap_step_clamp got %0d/%b want 5/1", w_cnt, w_wrap); end
        drive(0, 0, 0, 1, 1, 0); cycle();
        checks++; if (w_cnt !== 4'd5 || w_wrap !== 1'b0) begin errors++; $display("FAIL step_zero_hold got %0d/%b want 5/0", w_cnt, w_wrap); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask

    task automatic test_sat();
        drive(0, 1, 8, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 1, 3); cycle();
        checks++; if (s_cnt !== 4'd9 || s_sat !== 1'b1) begin errors++; $display("FAIL sat_up got %0d/%b want 9/1", s_cnt, s_sat); end
        checks++; if (s_at_max !== 1'b1) begin errors++; $display("FAIL sat_at_max got %b want 1", s_at_max); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (s_cnt !== 4'd9 || s_sat !== 1'b1) begin errors++; $display("FAIL sat_hold_%0d got %0d/%b want 9/1", i, s_cnt, s_sat); end
        end
        drive(0, 0, 0, 1, 0, 1); cycle();
        checks++; if (s_cnt !== 4'd8 || s_sat !== 1'b0) begin errors++; $display("FAIL sat_down got %0d/%b want 8/0", s_cnt, s_sat); end
        drive(0, 1, 3, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 0, 1); cycle();
        checks++; if (s_cnt !== 4'd2 || s_sat !== 1'b0 || s_at_min !== 1'b1) begin errors++; $display("FAIL sat_exact_min got %0d/%b want 2/0", s_cnt, s_sat); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask

    task automatic test_priority();
        drive(0, 1, 6, 0, 0, 0); cycle();
        drive(1, 1, 7, 1, 1, 3); cycle();
        checks++; if (w_cnt !== 4'd2 || s_cnt !== 4'd2) begin errors++; $display("FAIL prio_clr got %0d/%0d want 2/2", w_cnt, s_cnt); end
        checks++; if ({w_wrap, w_sat, s_wrap, s_sat} !== 4'b0000) begin errors++; $display("FAIL prio_clr_pulse got %b want 0000", {w_wrap, w_sat, s_wrap, s_sat}); end
        drive(0, 1, 12, 1, 1, 3); cycle();
        checks++; if (w_cnt !== 4'd9 || w_wrap !== 1'b0) begin errors++; $display("FAIL load_hi_clamp got %0d/%b want 9/0", w_cnt, w_wrap); end
        drive(0, 1, 0, 1, 0, 3); cycle();
        checks++; if (s_cnt !== 4'd2 || s_sat !== 1'b0) begin errors++; $display("FAIL load_lo_clamp got %0d/%b want 2/0", s_cnt, s_sat); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask

    task automatic test_async_reset();
        drive(0, 1, 6, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (w_cnt !== 4'd2 || s_cnt !== 4'd2) begin errors++; $display("FAIL async_reset got %0d/%0d want 2/2", w_cnt, s_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++; if (w_cnt !== 4'd3 || s_cnt !== 4'd3) begin errors++; $display("FAIL resume_after_reset got %0d/%0d want 3/3", w_cnt, s_cnt); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask

`ifdef SYS_CNTR_STICKY_EN
    task automatic test_sticky();
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 8, 0, 0, 0); cycle();
        checks++; if (w_sticky !== 1'b0) begin errors++; $display("FAIL sticky_idle got %b want 0", w_sticky); end
        drive(0, 0, 0, 1, 1, 3); cycle();
        checks++; if (w_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got %b want 1", w_sticky); end
        drive(0, 0, 0, 0, 0, 0);
        repeat (10) cycle();
        drive(0, 1, 4, 0, 0, 0); cycle();
        checks++; if (w_sticky !== 1'b1) begin errors++; $display("FAIL sticky_hold got %b want 1", w_sticky); end
        drive(1, 0, 0, 0, 0, 0); cycle();
        checks++; if (w_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got %b want 0", w_sticky); end
        drive(0, 0, 0, 0, 0, 0); cycle();
    endtask
`endif

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(99, 0));
            drive(r < 4, (r >= 4 && r < 14), int'($urandom_range(15, 0)),
                  $urandom_range(99, 0) < 75, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)));
            cycle();
            checks++; if (w_cnt !== 4'(m_w_cnt) || w_wrap !== m_w_wrap || w_sat !== 1'b0) begin
                errors++; $display("FAIL rand_wrap[%0d] got %0d/%b/%b want %0d/%b/0", i, w_cnt, w_wrap, w_sat, m_w_cnt, m_w_wrap);
            end
            checks++; if (s_cnt !== 4'(m_s_cnt) || s_sat !== m_s_sat || s_wrap !== 1'b0) begin
                errors++; $display("FAIL rand_sat[%0d] got %0d/%b/%b want %0d/%b/0", i, s_cnt, s_sat, s_wrap, m_s_cnt, m_s_sat);
            end
            checks++; if (w_at_max !== (m_w_cnt == MAX_I) || w_at_min !== (m_w_cnt == MIN_I) ||
                          s_at_max !== (m_s_cnt == MAX_I) || s_at_min !== (m_s_cnt == MIN_I)) begin
                errors++; $display("FAIL rand_flags[%0d] got %b%b%b%b", i, w_at_max, w_at_min, s_at_max, s_at_min);
            end
`ifdef SYS_CNTR_STICKY_EN
            checks++; if (w_sticky !== m_w_sticky || s_sticky !== m_s_sticky) begin
                errors++; $display("FAIL rand_sticky[%0d] got %b%b want %b%b", i, w_sticky, s_sticky, m_w_sticky, m_s_sticky);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat();
        test_priority();
        test_async_reset();
`ifdef SYS_CNTR_STICKY_EN
        test_sticky();
`endif
        test_wrap_up();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
